// File: rtl/pcie_tl_pkg.sv
// Shared widths, thresholds and in-flight payload type for the final arbitration stage.
package pcie_tl_pkg;

    localparam int unsigned DATA_WIDTH      = 6;
    localparam int unsigned ADDRESS_WIDTH   = 2;
    localparam int unsigned ROUTE_BIT       = 4;
    localparam int unsigned ALMOST_FULL_TH  = 3;
    localparam int unsigned ALMOST_EMPTY_TH = 1;

    // Which virtual channel the word in flight was read from.
    typedef enum logic {
        SRC_VC0 = 1'b0,
        SRC_VC1 = 1'b1
    } vc_src_e;

    // Read issued last cycle; the VC data port carries its word this cycle.
    typedef struct packed {
        logic    valid;
        vc_src_e src;
    } inflight_t;

endpackage

// File: rtl/fifo_dest.sv
// Destination FIFO: 4-deep, registered read port, registered status flags, sticky error.
module fifo_dest #(
    parameter int unsigned DATA_WIDTH    = pcie_tl_pkg::DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = pcie_tl_pkg::ADDRESS_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  error
);

    localparam int unsigned DEPTH = 2 ** ADDRESS_WIDTH;
    localparam int unsigned CW    = ADDRESS_WIDTH + 1;

    logic [DATA_WIDTH-1:0]    mem [DEPTH];
    logic [ADDRESS_WIDTH-1:0] wr_ptr;
    logic [ADDRESS_WIDTH-1:0] rd_ptr;
    logic [CW-1:0]            count;
    logic [CW-1:0]            count_nxt;
    logic                     is_full;
    logic                     is_empty;
    logic                     do_push;
    logic                     do_pop;
    logic                     err_evt;

    // Accept/reject decisions and next occupancy; a pop frees the slot a same-cycle push needs.
    always_comb begin
        is_full   = (count == CW'(DEPTH));
        is_empty  = (count == '0);
        do_pop    = pop && !is_empty;
        do_push   = push && (!is_full || do_pop);
        err_evt   = (push && is_full && !pop) || (pop && is_empty);
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + CW'(1);
        end else if (!do_push && do_pop) begin
            count_nxt = count - CW'(1);
        end
    end

    // Storage array; holds no reset so it maps onto plain flops or a small RAM.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy, read register and flags derived from next occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            data_out     <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b0;
            error        <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + ADDRESS_WIDTH'(1);
            end
            if (do_pop) begin
                data_out <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + ADDRESS_WIDTH'(1);
            end
            count        <= count_nxt;
            full         <= (count_nxt == CW'(DEPTH));
            empty        <= (count_nxt == '0);
            almost_full  <= (count_nxt >= CW'(pcie_tl_pkg::ALMOST_FULL_TH));
            almost_empty <= (count_nxt == CW'(pcie_tl_pkg::ALMOST_EMPTY_TH));
            if (err_evt) begin
                error <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/final_logic.sv
// Final stage: strict-priority VC arbiter feeding two destination FIFOs routed on a header bit.
module final_logic #(
    parameter int unsigned DATA_WIDTH    = pcie_tl_pkg::DATA_WIDTH,
    parameter int unsigned ADDRESS_WIDTH = pcie_tl_pkg::ADDRESS_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_out_VC0,
    input  logic                  empty_fifo_VC0,
    input  logic [DATA_WIDTH-1:0] data_out_VC1,
    input  logic                  empty_fifo_VC1,
    input  logic                  pop_D0,
    input  logic                  pop_D1,
    output logic                  pop_VC0_fifo,
    output logic                  pop_VC1_fifo,
    output logic [DATA_WIDTH-1:0] data_out_D0,
    output logic [DATA_WIDTH-1:0] data_out_D1,
    output logic                  full_D0,
    output logic                  empty_D0,
    output logic                  almost_full_D0,
    output logic                  almost_empty_D0,
    output logic                  error_D0,
    output logic                  full_D1,
    output logic                  empty_D1,
    output logic                  almost_full_D1,
    output logic                  almost_empty_D1,
    output logic                  error_D1
);

    pcie_tl_pkg::inflight_t inflight;
    logic                   pause;
    logic [DATA_WIDTH-1:0]  push_word;
    logic                   push_d0;
    logic                   push_d1;

    // Arbiter: VC0 wins; stall while either destination could overflow with one word in flight.
    always_comb begin
        pause        = almost_full_D0 | almost_full_D1;
        pop_VC0_fifo = !reset && !empty_fifo_VC0 && !pause;
        pop_VC1_fifo = !reset && empty_fifo_VC0 && !empty_fifo_VC1 && !pause;
    end

    // Remember which VC was read so its data can be captured one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight <= '{valid: 1'b0, src: pcie_tl_pkg::SRC_VC0};
        end else begin
            inflight.valid <= pop_VC0_fifo | pop_VC1_fifo;
            inflight.src   <= pop_VC1_fifo ? pcie_tl_pkg::SRC_VC1 : pcie_tl_pkg::SRC_VC0;
        end
    end

    // Router: select the returning word and steer it by its route bit.
    always_comb begin
        push_word = (inflight.src == pcie_tl_pkg::SRC_VC1) ? data_out_VC1 : data_out_VC0;
        push_d0   = inflight.valid && !push_word[pcie_tl_pkg::ROUTE_BIT];
        push_d1   = inflight.valid && push_word[pcie_tl_pkg::ROUTE_BIT];
    end

    fifo_dest #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_fifo_d0 (
        .clk          (clk),
        .reset        (reset),
        .push         (push_d0),
        .push_data    (push_word),
        .pop          (pop_D0),
        .data_out     (data_out_D0),
        .full         (full_D0),
        .empty        (empty_D0),
        .almost_full  (almost_full_D0),
        .almost_empty (almost_empty_D0),
        .error        (error_D0)
    );

    fifo_dest #(
        .DATA_WIDTH    (DATA_WIDTH),
        .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_fifo_d1 (
        .clk          (clk),
        .reset        (reset),
        .push         (push_d1),
        .push_data    (push_word),
        .pop          (pop_D1),
        .data_out     (data_out_D1),
        .full         (full_D1),
        .empty        (empty_D1),
        .almost_full  (almost_full_D1),
        .almost_empty (almost_empty_D1),
        .error        (error_D1)
    );

endmodule

// File: tb/tb_final_logic.sv
// Bench for final_logic: queue-based model of VCs and destination FIFOs plus directed scenarios.
module tb_final_logic;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] data_out_VC0, data_out_VC1;
    logic       empty_fifo_VC0, empty_fifo_VC1;
    logic       pop_D0, pop_D1;
    logic       pop_VC0_fifo, pop_VC1_fifo;
    logic [5:0] data_out_D0, data_out_D1;
    logic       full_D0, empty_D0, almost_full_D0, almost_empty_D0, error_D0;
    logic       full_D1, empty_D1, almost_full_D1, almost_empty_D1, error_D1;

    always #5 clk = ~clk;

    final_logic #(.DATA_WIDTH(6), .ADDRESS_WIDTH(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .data_out_VC0    (data_out_VC0),
        .empty_fifo_VC0  (empty_fifo_VC0),
        .data_out_VC1    (data_out_VC1),
        .empty_fifo_VC1  (empty_fifo_VC1),
        .pop_D0          (pop_D0),
        .pop_D1          (pop_D1),
        .pop_VC0_fifo    (pop_VC0_fifo),
        .pop_VC1_fifo    (pop_VC1_fifo),
        .data_out_D0     (data_out_D0),
        .data_out_D1     (data_out_D1),
        .full_D0         (full_D0),
        .empty_D0        (empty_D0),
        .almost_full_D0  (almost_full_D0),
        .almost_empty_D0 (almost_empty_D0),
        .error_D0        (error_D0),
        .full_D1         (full_D1),
        .empty_D1        (empty_D1),
        .almost_full_D1  (almost_full_D1),
        .almost_empty_D1 (almost_empty_D1),
        .error_D1        (error_D1)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Model: VC contents, destination contents, read registers, sticky errors, word in flight.
    logic [5:0] vc0_q[$];
    logic [5:0] vc1_q[$];
    logic [5:0] d0_q[$];
    logic [5:0] d1_q[$];
    logic [5:0] m_dout0, m_dout1;
    bit         m_err0, m_err1;
    bit         m_inf_valid;
    logic [5:0] m_inf_word;
    bit         s_pop_d0, s_pop_d1;
    bit         seen_pop0, seen_pop1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        d0_q.delete();
        d1_q.delete();
        m_dout0     = '0;
        m_dout1     = '0;
        m_err0      = 1'b0;
        m_err1      = 1'b0;
        m_inf_valid = 1'b0;
    endtask

    // Registered outputs versus the model after every clock.
    task automatic compare_outputs();
        check("d0_data",  32'(data_out_D0),     32'(m_dout0));
        check("d0_full",  32'(full_D0),         32'(d0_q.size() == 4));
        check("d0_empty", 32'(empty_D0),        32'(d0_q.size() == 0));
        check("d0_afull", 32'(almost_full_D0),  32'(d0_q.size() >= 3));
        check("d0_aempt", 32'(almost_empty_D0), 32'(d0_q.size() == 1));
        check("d0_error", 32'(error_D0),        32'(m_err0));
        check("d1_data",  32'(data_out_D1),     32'(m_dout1));
        check("d1_full",  32'(full_D1),         32'(d1_q.size() == 4));
        check("d1_empty", 32'(empty_D1),        32'(d1_q.size() == 0));
        check("d1_afull", 32'(almost_full_D1),  32'(d1_q.size() >= 3));
        check("d1_aempt", 32'(almost_empty_D1), 32'(d1_q.size() == 1));
        check("d1_error", 32'(error_D1),        32'(m_err1));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pop0"},  32'(pop_VC0_fifo),    32'(0));
        check({tag, "_pop1"},  32'(pop_VC1_fifo),    32'(0));
        check({tag, "_dout0"}, 32'(data_out_D0),     32'(0));
        check({tag, "_dout1"}, 32'(data_out_D1),     32'(0));
        check({tag, "_empt0"}, 32'(empty_D0),        32'(1));
        check({tag, "_empt1"}, 32'(empty_D1),        32'(1));
        check({tag, "_full0"}, 32'(full_D0),         32'(0));
        check({tag, "_full1"}, 32'(full_D1),         32'(0));
        check({tag, "_af0"},   32'(almost_full_D0),  32'(0));
        check({tag, "_af1"},   32'(almost_full_D1),  32'(0));
        check({tag, "_ae0"},   32'(almost_empty_D0), 32'(0));
        check({tag, "_ae1"},   32'(almost_empty_D1), 32'(0));
        check({tag, "_err0"},  32'(error_D0),        32'(0));
        check({tag, "_err1"},  32'(error_D1),        32'(0));
    endtask

    // One clock: drive inputs at negedge, check arbiter, advance model, check registered outputs.
    task automatic cycle();
        bit         ep0, ep1, pause_m, pw0, pw1;
        int         n0, n1;
        logic [5:0] w;
        empty_fifo_VC0 = (vc0_q.size() == 0);
        empty_fifo_VC1 = (vc1_q.size() == 0);
        pop_D0         = s_pop_d0;
        pop_D1         = s_pop_d1;
        #1;
        pause_m = (d0_q.size() >= 3) || (d1_q.size() >= 3);
        ep0     = !empty_fifo_VC0 && !pause_m;
        ep1     = empty_fifo_VC0 && !empty_fifo_VC1 && !pause_m;
        seen_pop0 = pop_VC0_fifo;
        seen_pop1 = pop_VC1_fifo;
        check("pop_vc0", 32'(pop_VC0_fifo), 32'(ep0));
        check("pop_vc1", 32'(pop_VC1_fifo), 32'(ep1));
        check("pop_both", 32'(pop_VC0_fifo & pop_VC1_fifo), 32'(0));
        w   = m_inf_word;
        pw0 = m_inf_valid && !w[4];
        pw1 = m_inf_valid && w[4];
        n0  = d0_q.size();
        if (s_pop_d0) begin
            if (n0 > 0) m_dout0 = d0_q.pop_front();
            else        m_err0  = 1'b1;
        end
        if (pw0) begin
            if (n0 == 4 && !s_pop_d0) m_err0 = 1'b1;
            else                      d0_q.push_back(w);
        end
        n1 = d1_q.size();
        if (s_pop_d1) begin
            if (n1 > 0) m_dout1 = d1_q.pop_front();
            else        m_err1  = 1'b1;
        end
        if (pw1) begin
            if (n1 == 4 && !s_pop_d1) m_err1 = 1'b1;
            else                      d1_q.push_back(w);
        end
        m_inf_valid = ep0 || ep1;
        if (ep0)      m_inf_word = vc0_q.pop_front();
        else if (ep1) m_inf_word = vc1_q.pop_front();
        @(posedge clk);
        #1;
        if (ep0) data_out_VC0 = m_inf_word;
        if (ep1) data_out_VC1 = m_inf_word;
        @(negedge clk);
        compare_outputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp_p0 [6] = '{1, 1, 0, 0, 0, 0};
        bit exp_p1 [6] = '{0, 0, 1, 1, 0, 0};
        reset          = 1'b1;
        data_out_VC0   = '0;
        data_out_VC1   = '0;
        empty_fifo_VC0 = 1'b1;
        empty_fifo_VC1 = 1'b1;
        pop_D0         = 1'b0;
        pop_D1         = 1'b0;
        s_pop_d0       = 1'b0;
        s_pop_d1       = 1'b0;
        m_inf_word     = '0;
        model_reset();
        #2;
        check_reset_values("rst_init");
        @(negedge clk);
        reset = 1'b0;

        // Two VC0 words split across destinations by bit 4.
        vc0_q.push_back(6'h05);
        vc0_q.push_back(6'h15);
        cycle();
        cycle();
        check("s1_empty_d0", 32'(empty_D0), 32'(0));
        cycle();
        check("s1_empty_d1", 32'(empty_D1), 32'(0));
        s_pop_d0 = 1'b1;
        s_pop_d1 = 1'b1;
        cycle();
        s_pop_d0 = 1'b0;
        s_pop_d1 = 1'b0;
        check("s1_dout_d0", 32'(data_out_D0), 32'(6'h05));
        check("s1_dout_d1", 32'(data_out_D1), 32'(6'h15));

        // Strict priority: VC0 drains completely before VC1 is served.
        vc0_q.push_back(6'h01);
        vc0_q.push_back(6'h02);
        vc1_q.push_back(6'h13);
        vc1_q.push_back(6'h14);
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("s2_order_vc0", 32'(seen_pop0), 32'(exp_p0[i]));
            check("s2_order_vc1", 32'(seen_pop1), 32'(exp_p1[i]));
        end
        s_pop_d0 = 1'b1;
        s_pop_d1 = 1'b1;
        cycle();
        cycle();
        s_pop_d0 = 1'b0;
        s_pop_d1 = 1'b0;
        check("s2_dout_d0", 32'(data_out_D0), 32'(6'h02));
        check("s2_dout_d1", 32'(data_out_D1), 32'(6'h14));

        // Back-pressure: eight D0-bound words, no downstream reads.
        for (int i = 0; i < 8; i++) vc0_q.push_back(6'(i));
        for (int i = 0; i < 12; i++) cycle();
        check("s3_full_d0",  32'(full_D0),        32'(1));
        check("s3_af_d0",    32'(almost_full_D0), 32'(1));
        check("s3_err_d0",   32'(error_D0),       32'(0));
        check("s3_vc0_left", 32'(vc0_q.size()),   32'(4));

        // Drain while full; traffic resumes and push/pop overlap; pointers wrap.
        s_pop_d0 = 1'b1;
        cycle();
        check("s4_oldest", 32'(data_out_D0), 32'(6'h00));
        check("s4_err_d0", 32'(error_D0),    32'(0));
        for (int i = 0; i < 7; i++) cycle();
        s_pop_d0 = 1'b0;
        check("s4_last_d0",  32'(data_out_D0), 32'(6'h07));
        check("s4_empty_d0", 32'(empty_D0),    32'(1));
        check("s4_err_end",  32'(error_D0),    32'(0));

        // Underflow on D1: sticky error, read register untouched.
        s_pop_d1 = 1'b1;
        cycle();
        s_pop_d1 = 1'b0;
        check("s5_err_d1",  32'(error_D1),    32'(1));
        check("s5_dout_d1", 32'(data_out_D1), 32'(6'h14));
        for (int i = 0; i < 3; i++) cycle();
        check("s5_sticky", 32'(error_D1), 32'(1));

        // Reset lands while a VC1 word is in flight: word is lost, outputs clear at once.
        vc1_q.push_back(6'h03);
        vc1_q.push_back(6'h13);
        cycle();
        empty_fifo_VC1 = (vc1_q.size() == 0);
        reset = 1'b1;
        #1;
        check_reset_values("rst_mid");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) cycle();
        check("s6_empty_d0", 32'(empty_D0), 32'(1));
        check("s6_empty_d1", 32'(empty_D1), 32'(0));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
